// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS execute-stage constants: widths, ALU op bit
//               indices and requester source encoding.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mips_pkg;

  localparam int MIPS_DATA_WIDTH   = 32;
  localparam int MIPS_ALU_OP_WIDTH = 14;

  // Bit positions inside the one-hot ALU operation vector
  localparam int MIPS_ALU_OP_ADD  = 0;
  localparam int MIPS_ALU_OP_ADDU = 1;
  localparam int MIPS_ALU_OP_SUB  = 2;
  localparam int MIPS_ALU_OP_SUBU = 3;
  localparam int MIPS_ALU_OP_AND  = 4;
  localparam int MIPS_ALU_OP_OR   = 5;
  localparam int MIPS_ALU_OP_XOR  = 6;
  localparam int MIPS_ALU_OP_NOR  = 7;
  localparam int MIPS_ALU_OP_SLL  = 8;
  localparam int MIPS_ALU_OP_SRL  = 9;
  localparam int MIPS_ALU_OP_SRA  = 10;
  localparam int MIPS_ALU_OP_SLT  = 11;
  localparam int MIPS_ALU_OP_SLTU = 12;
  localparam int MIPS_ALU_OP_LUI  = 13;

  localparam logic MIPS_ALU_SRC_RGLR = 1'b0;
  localparam logic MIPS_ALU_SRC_AUX  = 1'b1;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/mips_ex_alu_core.sv
// ============================================================================
// Module      : mips_ex_alu_core
// Description : Combinational ALU: result, signed overflow and illegal-op flag
//               from two operands and a one-hot operation vector.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mips_ex_alu_core
  import mips_pkg::*;
#(
  parameter int DW  = MIPS_DATA_WIDTH,
  parameter int OPW = MIPS_ALU_OP_WIDTH
) (
  input  logic [DW-1:0]  op1_i,
  input  logic [DW-1:0]  op2_i,
  input  logic [OPW-1:0] op_i,
  output logic [DW-1:0]  result_o,
  output logic           ovf_o,
  output logic           illegal_o
);

  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic [4:0]    shamt;
  logic          onehot;
  logic          add_ovf;
  logic          sub_ovf;
  logic          slt_bit;
  logic          sltu_bit;

  assign sum      = op1_i + op2_i;
  assign diff     = op1_i - op2_i;
  assign shamt    = op1_i[4:0];
  assign onehot   = (op_i != '0) && ((op_i & (op_i - OPW'(1))) == '0);
  assign add_ovf  = (op1_i[DW-1] == op2_i[DW-1]) && (sum[DW-1]  != op1_i[DW-1]);
  assign sub_ovf  = (op1_i[DW-1] != op2_i[DW-1]) && (diff[DW-1] != op1_i[DW-1]);
  assign slt_bit  = $signed(op1_i) < $signed(op2_i);
  assign sltu_bit = op1_i < op2_i;

  // A malformed op vector forces a zero result with no overflow
  always_comb begin
    result_o  = '0;
    ovf_o     = 1'b0;
    illegal_o = !onehot;
    if (onehot) begin
      case (1'b1)
        op_i[MIPS_ALU_OP_ADD]:  begin result_o = sum;  ovf_o = add_ovf; end
        op_i[MIPS_ALU_OP_ADDU]: result_o = sum;
        op_i[MIPS_ALU_OP_SUB]:  begin result_o = diff; ovf_o = sub_ovf; end
        op_i[MIPS_ALU_OP_SUBU]: result_o = diff;
        op_i[MIPS_ALU_OP_AND]:  result_o = op1_i & op2_i;
        op_i[MIPS_ALU_OP_OR]:   result_o = op1_i | op2_i;
        op_i[MIPS_ALU_OP_XOR]:  result_o = op1_i ^ op2_i;
        op_i[MIPS_ALU_OP_NOR]:  result_o = ~(op1_i | op2_i);
        op_i[MIPS_ALU_OP_SLL]:  result_o = op2_i << shamt;
        op_i[MIPS_ALU_OP_SRL]:  result_o = op2_i >> shamt;
        op_i[MIPS_ALU_OP_SRA]:  result_o = $signed(op2_i) >>> shamt;
        op_i[MIPS_ALU_OP_SLT]:  result_o = {{(DW-1){1'b0}}, slt_bit};
        op_i[MIPS_ALU_OP_SLTU]: result_o = {{(DW-1){1'b0}}, sltu_bit};
        op_i[MIPS_ALU_OP_LUI]:  result_o = {op2_i[15:0], {(DW-16){1'b0}}};
        default:                result_o = '0;
      endcase
    end
  end

endmodule : mips_ex_alu_core

`default_nettype wire

// File: rtl/mips_ex_alu_dpath.sv
// ============================================================================
// Module      : mips_ex_alu_dpath
// Description : Execute-stage shared ALU: round-robin arbitration between the
//               regular and auxiliary requesters, one registered response.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mips_ex_alu_dpath
  import mips_pkg::*;
#(
  parameter int DW  = MIPS_DATA_WIDTH,
  parameter int OPW = MIPS_ALU_OP_WIDTH
) (
  input  logic           clk,
  input  logic           rst,

  input  logic           rglr_req_valid,
  output logic           rglr_req_ready,
  input  logic [DW-1:0]  rglr_req_op1,
  input  logic [DW-1:0]  rglr_req_op2,
  input  logic [OPW-1:0] rglr_req_op,

  input  logic           aux_req_valid,
  output logic           aux_req_ready,
  input  logic [DW-1:0]  aux_req_op1,
  input  logic [DW-1:0]  aux_req_op2,
  input  logic [OPW-1:0] aux_req_op,

  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_result,
  output logic           rsp_ovf,
  output logic           rsp_illegal,
  output logic           rsp_src
);

  logic          last_grant_q, last_grant_d;
  logic          rsp_valid_q,  rsp_valid_d;
  logic [DW-1:0] rsp_result_q, rsp_result_d;
  logic          rsp_ovf_q,    rsp_ovf_d;
  logic          rsp_illegal_q, rsp_illegal_d;
  logic          rsp_src_q,    rsp_src_d;

  logic           grant;
  logic           slot_free;
  logic           accept;
  logic [DW-1:0]  sel_op1;
  logic [DW-1:0]  sel_op2;
  logic [OPW-1:0] sel_op;
  logic [DW-1:0]  core_result;
  logic           core_ovf;
  logic           core_illegal;

  // Under contention the port that did not win last time is granted
  always_comb begin
    if (rglr_req_valid && aux_req_valid) begin
      grant = ~last_grant_q;
    end else if (aux_req_valid) begin
      grant = MIPS_ALU_SRC_AUX;
    end else begin
      grant = MIPS_ALU_SRC_RGLR;
    end
  end

  assign slot_free      = !rsp_valid_q || rsp_ready;
  assign rglr_req_ready = !rst && slot_free && (grant == MIPS_ALU_SRC_RGLR);
  assign aux_req_ready  = !rst && slot_free && (grant == MIPS_ALU_SRC_AUX);
  assign accept         = (rglr_req_valid && rglr_req_ready) ||
                          (aux_req_valid  && aux_req_ready);

  assign sel_op1 = (grant == MIPS_ALU_SRC_AUX) ? aux_req_op1 : rglr_req_op1;
  assign sel_op2 = (grant == MIPS_ALU_SRC_AUX) ? aux_req_op2 : rglr_req_op2;
  assign sel_op  = (grant == MIPS_ALU_SRC_AUX) ? aux_req_op  : rglr_req_op;

  mips_ex_alu_core #(
    .DW  (DW),
    .OPW (OPW)
  ) u_core (
    .op1_i     (sel_op1),
    .op2_i     (sel_op2),
    .op_i      (sel_op),
    .result_o  (core_result),
    .ovf_o     (core_ovf),
    .illegal_o (core_illegal)
  );

  // An accept overwrites the slot even while it drains, so there is no bubble
  always_comb begin
    last_grant_d  = last_grant_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_ovf_d     = rsp_ovf_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_src_d     = rsp_src_q;
    if (accept) begin
      last_grant_d  = grant;
      rsp_valid_d   = 1'b1;
      rsp_result_d  = core_result;
      rsp_ovf_d     = core_ovf;
      rsp_illegal_d = core_illegal;
      rsp_src_d     = grant;
    end else if (rsp_ready) begin
      rsp_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q  <= MIPS_ALU_SRC_AUX;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_ovf_q     <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_src_q     <= MIPS_ALU_SRC_RGLR;
    end else begin
      last_grant_q  <= last_grant_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_ovf_q     <= rsp_ovf_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_src_q     <= rsp_src_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_ovf     = rsp_ovf_q;
  assign rsp_illegal = rsp_illegal_q;
  assign rsp_src     = rsp_src_q;

endmodule : mips_ex_alu_dpath

`default_nettype wire

// File: tb/tb_mips_ex_alu_dpath.sv
// ============================================================================
// Module      : tb_mips_ex_alu_dpath
// Description : Self-checking bench for the shared execute-stage ALU datapath.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mips_ex_alu_dpath;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rglr_req_valid = 1'b0;
  logic        rglr_req_ready;
  logic [31:0] rglr_req_op1 = '0;
  logic [31:0] rglr_req_op2 = '0;
  logic [13:0] rglr_req_op  = '0;
  logic        aux_req_valid = 1'b0;
  logic        aux_req_ready;
  logic [31:0] aux_req_op1 = '0;
  logic [31:0] aux_req_op2 = '0;
  logic [13:0] aux_req_op  = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_ovf;
  logic        rsp_illegal;
  logic        rsp_src;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: what the response slot should hold
  logic        m_valid, m_src, m_last, m_ovf, m_ill;
  logic [31:0] m_res;

  always #5 clk = ~clk;

  mips_ex_alu_dpath #(.DW(32), .OPW(14)) dut (
    .clk            (clk),
    .rst            (rst),
    .rglr_req_valid (rglr_req_valid),
    .rglr_req_ready (rglr_req_ready),
    .rglr_req_op1   (rglr_req_op1),
    .rglr_req_op2   (rglr_req_op2),
    .rglr_req_op    (rglr_req_op),
    .aux_req_valid  (aux_req_valid),
    .aux_req_ready  (aux_req_ready),
    .aux_req_op1    (aux_req_op1),
    .aux_req_op2    (aux_req_op2),
    .aux_req_op     (aux_req_op),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_ovf        (rsp_ovf),
    .rsp_illegal    (rsp_illegal),
    .rsp_src        (rsp_src)
  );

  function automatic void alu_ref(input logic [13:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ovf, output logic ill);
    longint sa, sb, exact;
    logic signed [31:0] sbv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sbv = b;
    r = '0; ovf = 1'b0; ill = 1'b0;
    case (op)
      14'h0001: begin r = a + b; exact = sa + sb; ovf = (exact != longint'($signed(r))); end
      14'h0002: r = a + b;
      14'h0004: begin r = a - b; exact = sa - sb; ovf = (exact != longint'($signed(r))); end
      14'h0008: r = a - b;
      14'h0010: r = a & b;
      14'h0020: r = a | b;
      14'h0040: r = a ^ b;
      14'h0080: r = ~(a | b);
      14'h0100: r = b << a[4:0];
      14'h0200: r = b >> a[4:0];
      14'h0400: r = sbv >>> a[4:0];
      14'h0800: r = (sa < sb) ? 32'd1 : 32'd0;
      14'h1000: r = (a < b) ? 32'd1 : 32'd0;
      14'h2000: r = b * 32'd65536;
      default:  ill = 1'b1;
    endcase
  endfunction

  function automatic logic [13:0] rand_op();
    if ($urandom_range(0, 9) < 8) return 14'(1) << $urandom_range(0, 13);
    return 14'($urandom);
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_src = 1'b0; m_last = 1'b1;
    m_ovf = 1'b0; m_ill = 1'b0; m_res = '0;
  endtask

  // One clock of stimulus; returns the observed and predicted handshakes
  task automatic step(input logic rv, input logic [13:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                      input logic av, input logic [13:0] aop, input logic [31:0] aa, input logic [31:0] ab,
                      input logic rr,
                      output logic got_r, output logic got_a, output logic exp_r, output logic exp_a);
    logic [31:0] r;
    logic o, i;
    @(negedge clk);
    rst = 1'b0;
    rglr_req_valid = rv; rglr_req_op = rop; rglr_req_op1 = ra; rglr_req_op2 = rb;
    aux_req_valid  = av; aux_req_op  = aop; aux_req_op1  = aa; aux_req_op2  = ab;
    rsp_ready = rr;
    #1;
    got_r = rglr_req_valid && rglr_req_ready;
    got_a = aux_req_valid && aux_req_ready;
    exp_r = 1'b0; exp_a = 1'b0;
    if (!m_valid || rr) begin
      if (rv && av) begin
        if (m_last) exp_r = 1'b1; else exp_a = 1'b1;
      end else if (rv) exp_r = 1'b1;
      else if (av) exp_a = 1'b1;
    end
    @(posedge clk);
    if (exp_r || exp_a) begin
      if (exp_r) alu_ref(rop, ra, rb, r, o, i);
      else       alu_ref(aop, aa, ab, r, o, i);
      m_valid = 1'b1; m_res = r; m_ovf = o; m_ill = i; m_src = exp_a; m_last = exp_a;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; rglr_req_valid = 1'b1; aux_req_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    vectors++;
    if (rglr_req_ready !== 1'b0 || aux_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got rglr=%b aux=%b expected 0/0", rglr_req_ready, aux_req_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({rsp_valid, rsp_ovf, rsp_illegal, rsp_src} !== 4'b0000 || rsp_result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b ovf=%b ill=%b src=%b res=%h expected all zero",
               rsp_valid, rsp_ovf, rsp_illegal, rsp_src, rsp_result);
    end
    @(negedge clk);
    rst = 1'b0; rglr_req_valid = 1'b0; aux_req_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_contention();
    logic gr, ga, er, ea;
    logic exp_src [4];
    exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int n = 0; n < 4; n++) begin
      step(1'b1, 14'h0001, 32'(n), 32'd100, 1'b1, 14'h0020, 32'(n), 32'h100, 1'b1, gr, ga, er, ea);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_src !== exp_src[n] || gr !== ~exp_src[n] || ga !== exp_src[n]) begin
        miscompares++;
        $display("FAIL contention[%0d]: got v=%b src=%b accR=%b accA=%b expected src=%b",
                 n, rsp_valid, rsp_src, gr, ga, exp_src[n]);
      end
      vectors++;
      if (rsp_result !== m_res) begin
        miscompares++;
        $display("FAIL contention_res[%0d]: got %h expected %h", n, rsp_result, m_res);
      end
    end
  endtask

  task automatic test_add_ovf();
    logic gr, ga, er, ea;
    step(1'b1, 14'h0001, 32'h7FFF_FFFF, 32'h1, 1'b0, '0, '0, '0, 1'b1, gr, ga, er, ea);
    vectors++;
    if (gr !== 1'b1 || rsp_result !== 32'h8000_0000 || rsp_ovf !== 1'b1 || rsp_src !== 1'b0) begin
      miscompares++;
      $display("FAIL add_ovf: got acc=%b res=%h ovf=%b src=%b expected 1/80000000/1/0",
               gr, rsp_result, rsp_ovf, rsp_src);
    end
    step(1'b1, 14'h0002, 32'h7FFF_FFFF, 32'h1, 1'b0, '0, '0, '0, 1'b1, gr, ga, er, ea);
    vectors++;
    if (rsp_result !== 32'h8000_0000 || rsp_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL addu_noovf: got res=%h ovf=%b expected 80000000/0", rsp_result, rsp_ovf);
    end
  endtask

  task automatic test_ops();
    logic gr, ga, er, ea;
    logic [13:0] t_op  [5];
    logic [31:0] t_a   [5];
    logic [31:0] t_b   [5];
    logic [31:0] t_exp [5];
    t_op  = '{14'h0400, 14'h0200, 14'h0800, 14'h1000, 14'h2000};
    t_a   = '{32'd4, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    t_b   = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd1, 32'h1234};
    t_exp = '{32'hF800_0000, 32'h0800_0000, 32'd1, 32'd0, 32'h1234_0000};
    for (int n = 0; n < 5; n++) begin
      step(1'b0, '0, '0, '0, 1'b1, t_op[n], t_a[n], t_b[n], 1'b1, gr, ga, er, ea);
      vectors++;
      if (ga !== 1'b1 || rsp_result !== t_exp[n] || rsp_illegal !== 1'b0 || rsp_src !== 1'b1) begin
        miscompares++;
        $display("FAIL op[%0d] op=%h: got acc=%b res=%h ill=%b src=%b expected res=%h",
                 n, t_op[n], ga, rsp_result, rsp_illegal, rsp_src, t_exp[n]);
      end
    end
  endtask

  task automatic test_illegal();
    logic gr, ga, er, ea;
    logic [13:0] bad [2];
    bad = '{14'h0000, 14'h0003};
    for (int n = 0; n < 2; n++) begin
      step(1'b1, bad[n], 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0, '0, '0, '0, 1'b1, gr, ga, er, ea);
      vectors++;
      if (gr !== 1'b1 || rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_illegal !== 1'b1 || rsp_ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal op=%h: got acc=%b v=%b res=%h ill=%b ovf=%b expected 1/1/0/1/0",
                 bad[n], gr, rsp_valid, rsp_result, rsp_illegal, rsp_ovf);
      end
    end
  endtask

  task automatic test_backpressure();
    logic gr, ga, er, ea;
    logic [31:0] held;
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b1, gr, ga, er, ea);
    step(1'b1, 14'h0040, 32'hAAAA_0000, 32'h5555_FFFF, 1'b0, '0, '0, '0, 1'b0, gr, ga, er, ea);
    held = m_res;
    vectors++;
    if (gr !== 1'b1 || rsp_valid !== 1'b1 || rsp_result !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL bp_accept: got acc=%b v=%b res=%h expected 1/1/ffffffff", gr, rsp_valid, rsp_result);
    end
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 14'h0001, 32'd1, 32'd2, 1'b1, 14'h0004, 32'd9, 32'd3, 1'b0, gr, ga, er, ea);
      vectors++;
      if (rglr_req_ready !== 1'b0 || aux_req_ready !== 1'b0 || rsp_valid !== 1'b1 ||
          rsp_result !== held || rsp_src !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got rdyR=%b rdyA=%b v=%b res=%h src=%b expected 0/0/1/%h/0",
                 n, rglr_req_ready, aux_req_ready, rsp_valid, rsp_result, rsp_src, held);
      end
    end
    step(1'b1, 14'h0001, 32'd1, 32'd2, 1'b1, 14'h0004, 32'd9, 32'd3, 1'b1, gr, ga, er, ea);
    vectors++;
    if (gr !== 1'b0 || ga !== 1'b1 || rsp_valid !== 1'b1 || rsp_src !== 1'b1 || rsp_result !== 32'd6) begin
      miscompares++;
      $display("FAIL bp_release: got accR=%b accA=%b v=%b src=%b res=%h expected 0/1/1/1/6",
               gr, ga, rsp_valid, rsp_src, rsp_result);
    end
  endtask

  task automatic test_random();
    logic gr, ga, er, ea;
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, rand_op(), rand_opnd(), rand_opnd(),
           $urandom_range(0, 2) != 0, rand_op(), rand_opnd(), rand_opnd(),
           $urandom_range(0, 3) != 0, gr, ga, er, ea);
      vectors++;
      if (gr !== er || ga !== ea || rsp_valid !== m_valid) begin
        miscompares++;
        $display("FAIL rand_hs[%0d]: got accR=%b accA=%b v=%b expected %b/%b/%b",
                 n, gr, ga, rsp_valid, er, ea, m_valid);
      end
      if (m_valid) begin
        vectors++;
        if (rsp_result !== m_res || rsp_ovf !== m_ovf || rsp_illegal !== m_ill || rsp_src !== m_src) begin
          miscompares++;
          $display("FAIL rand_rsp[%0d]: got res=%h ovf=%b ill=%b src=%b expected %h/%b/%b/%b",
                   n, rsp_result, rsp_ovf, rsp_illegal, rsp_src, m_res, m_ovf, m_ill, m_src);
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic gr, ga, er, ea;
    step(1'b0, '0, '0, '0, 1'b1, 14'h0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, gr, ga, er, ea);
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, gr, ga, er, ea);
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pending: got v=%b expected 1", rsp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b expected 0", rsp_valid);
    end
    model_reset();
    step(1'b1, 14'h0008, 32'd5, 32'd7, 1'b1, 14'h0001, 32'd1, 32'd1, 1'b1, gr, ga, er, ea);
    vectors++;
    if (gr !== 1'b1 || ga !== 1'b0 || rsp_src !== 1'b0 || rsp_result !== 32'hFFFF_FFFE || rsp_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_first_grant: got accR=%b accA=%b src=%b res=%h ovf=%b expected 1/0/0/fffffffe/0",
               gr, ga, rsp_src, rsp_result, rsp_ovf);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_contention();
    test_add_ovf();
    test_ops();
    test_illegal();
    test_backpressure();
    test_random();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mips_ex_alu_dpath

`default_nettype wire
